// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master frame engine.
package spi_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, STOP} spi_state_e;

  // Divider counter width; a one-cycle half-period still needs one bit.
  function automatic int div_w(input int div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/spi_master_xfer_if.sv
// Host handshake plus SPI pins for the frame engine.
interface spi_master_xfer_if #(
  parameter int DATA_W = 8
);
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] rx_data;
  logic              done;
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;

  modport master (
    input  tx_valid, tx_data, miso,
    output tx_ready, rx_data, done, sclk, cs_n, mosi
  );

  modport slave (
    output tx_valid, tx_data, miso,
    input  tx_ready, rx_data, done, sclk, cs_n, mosi
  );
endinterface

// File: rtl/spi_clk_div.sv
// Half-period tick generator: counts 0..CLK_DIV-1 and ticks on terminal count.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = div_w(CLK_DIV);
  localparam logic [W-1:0] TC = W'(CLK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == TC);

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/spi_master_xfer.sv
// Full-duplex SPI master: one frame per accepted word, all pins driven from flops.
module spi_master_xfer
  import spi_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 2,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  spi_master_xfer_if.master   bus
);
  localparam int EW = $clog2(2 * DATA_W) + 1;
  localparam logic [EW-1:0] NEDGE = EW'(2 * DATA_W);
  localparam logic [EW-1:0] LAST  = EW'(2 * DATA_W - 1);

  spi_state_e        state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d, rxs_q, rxs_d, rx_q, rx_d;
  logic [EW-1:0]     ecnt_q, ecnt_d;
  logic              sclk_q, sclk_d, cs_n_q, cs_n_d, mosi_q, mosi_d;
  logic              ready_q, ready_d, done_q, done_d;
  logic              tick, clr, accept, lead, last, smp, adv;

  function automatic logic first_bit(input logic [DATA_W-1:0] v);
    return MSB_FIRST ? v[DATA_W-1] : v[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v);
    return MSB_FIRST ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v, input logic b);
    return MSB_FIRST ? {v[DATA_W-2:0], b} : {b, v[DATA_W-1:1]};
  endfunction

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  assign accept = (state_q == IDLE) && bus.tx_valid && ready_q;
  assign lead   = ~ecnt_q[0];
  assign last   = (ecnt_q == LAST);
  assign smp    = CPHA ? ~lead : lead;
  // CPHA=0 presents bit 0 at accept, so the final trailing edge has nothing left to shift.
  assign adv    = CPHA ? lead : (~lead && ~last);
  assign clr    = accept || (state_d != state_q);

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    rxs_d   = rxs_q;
    rx_d    = rx_q;
    ecnt_d  = ecnt_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    mosi_d  = mosi_q;
    ready_d = ready_q;
    done_d  = done_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = SETUP;
        cs_n_d  = 1'b0;
        ready_d = 1'b0;
        ecnt_d  = '0;
        sh_d    = bus.tx_data;
        if (!CPHA) begin
          mosi_d = first_bit(bus.tx_data);
          sh_d   = shift_out(bus.tx_data);
        end
      end
      // Edge 0 fires on the tick that ends the CS lead time.
      SETUP, SHIFT: if (tick && ecnt_q != NEDGE) begin
        sclk_d  = ~sclk_q;
        ecnt_d  = ecnt_q + EW'(1);
        state_d = last ? HOLD : SHIFT;
        if (smp) rxs_d = shift_in(rxs_q, bus.miso);
        if (adv) begin
          mosi_d = first_bit(sh_q);
          sh_d   = shift_out(sh_q);
        end
      end
      HOLD: if (tick) begin
        state_d = STOP;
        cs_n_d  = 1'b1;
        done_d  = 1'b1;
        rx_d    = rxs_q;
        mosi_d  = 1'b0;
      end
      STOP: begin
        state_d = IDLE;
        done_d  = 1'b0;
        ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      rxs_q   <= '0;
      rx_q    <= '0;
      ecnt_q  <= '0;
      sclk_q  <= CPOL;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      rxs_q   <= rxs_d;
      rx_q    <= rx_d;
      ecnt_q  <= ecnt_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx_ready = ready_q;
  assign bus.rx_data  = rx_q;
  assign bus.done     = done_q;
  assign bus.sclk     = sclk_q;
  assign bus.cs_n     = cs_n_q;
  assign bus.mosi     = mosi_q;
endmodule

// File: tb/tb_spi_master_xfer.sv
// Directed bench: three engine configurations, viewed one at a time through a mux.
module tb_spi_master_xfer;
  logic        clk = 1'b0;
  logic        rst;
  logic        tx_valid;
  logic [31:0] tx_data;
  int          sel;
  int          n_chk = 0;
  int          n_err = 0;

  logic        m_sclk, m_cs_n, m_mosi, m_done, m_ready;
  logic [31:0] m_rx;

  always #5 clk = ~clk;

  spi_master_xfer_if #(.DATA_W(8))  bus0 ();
  spi_master_xfer_if #(.DATA_W(8))  bus1 ();
  spi_master_xfer_if #(.DATA_W(12)) bus2 ();

  assign bus0.tx_valid = tx_valid && (sel == 0);
  assign bus1.tx_valid = tx_valid && (sel == 1);
  assign bus2.tx_valid = tx_valid && (sel == 2);
  assign bus0.tx_data  = tx_data[7:0];
  assign bus1.tx_data  = tx_data[7:0];
  assign bus2.tx_data  = tx_data[11:0];
  assign bus0.miso     = bus0.mosi;
  assign bus1.miso     = 1'b1;
  assign bus2.miso     = bus2.mosi;

  spi_master_xfer u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  spi_master_xfer #(.CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  spi_master_xfer #(.DATA_W(12), .CLK_DIV(1)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always_comb begin
    case (sel)
      1: begin
        m_sclk = bus1.sclk; m_cs_n = bus1.cs_n; m_mosi = bus1.mosi;
        m_done = bus1.done; m_ready = bus1.tx_ready; m_rx = 32'(bus1.rx_data);
      end
      2: begin
        m_sclk = bus2.sclk; m_cs_n = bus2.cs_n; m_mosi = bus2.mosi;
        m_done = bus2.done; m_ready = bus2.tx_ready; m_rx = 32'(bus2.rx_data);
      end
      default: begin
        m_sclk = bus0.sclk; m_cs_n = bus0.cs_n; m_mosi = bus0.mosi;
        m_done = bus0.done; m_ready = bus0.tx_ready; m_rx = 32'(bus0.rx_data);
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // One frame on the selected engine; mosi is captured at every sclk rise.
  task automatic frame(input logic [31:0] d, input bit noisy,
                       output logic [31:0] bits, output int nb, output int cs_lo,
                       output int nd, output logic [31:0] rx);
    logic pv;
    int   post, w;
    bits = '0; nb = 0; cs_lo = 0; nd = 0; rx = '0; post = 0; w = 0;
    while (!m_ready && w < 200) begin @(negedge clk); w++; end
    pv = m_sclk;
    tx_data = d; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (!m_cs_n) cs_lo++;
      if (m_sclk && !pv) begin bits = {bits[30:0], m_mosi}; nb++; end
      pv = m_sclk;
      if (m_done) begin nd++; rx = m_rx; end
      if (nd > 0) post++;
      if (post > 4) break;
      if (noisy) begin
        tx_data  = $urandom;
        tx_valid = (post == 1) ? 1'b1 : (post > 1) ? 1'b0 : t[0];
      end
      @(negedge clk);
    end
    tx_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bits, rx, rx0, rx1;
    int nb, cs_lo, nd, acc, ph, gap, nt, w;
    logic pend, pv;

    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; sel = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(m_ready), 32'd1);
    chk("rst_done",  32'(m_done),  32'd0);
    chk("rst_sclk",  32'(m_sclk),  32'd0);
    chk("rst_cs_n",  32'(m_cs_n),  32'd1);
    chk("rst_mosi",  32'(m_mosi),  32'd0);
    chk("rst_rx",    m_rx,         32'd0);
    chk("rst_sclk_cpol1", 32'(bus1.sclk), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // mode 0 loopback: A5 -> 1,0,1,0,0,1,0,1
    sel = 0;
    frame(32'hA5, 1'b0, bits, nb, cs_lo, nd, rx);
    chk("t1_bits", bits, 32'hA5);
    chk("t1_nb", nb, 8);
    chk("t1_cs_lo", cs_lo, 34);
    chk("t1_done", nd, 1);
    chk("t1_rx", rx, 32'hA5);

    // mode 3, LSB first, miso=1: 3C -> 0,0,1,1,1,1,0,0
    sel = 1;
    @(negedge clk);
    chk("t2_idle_sclk", 32'(m_sclk), 32'd1);
    frame(32'h3C, 1'b0, bits, nb, cs_lo, nd, rx);
    chk("t2_bits", bits, 32'b0011_1100);
    chk("t2_nb", nb, 8);
    chk("t2_cs_lo", cs_lo, 34);
    chk("t2_done", nd, 1);
    chk("t2_rx", rx, 32'hFF);

    // back-to-back with tx_valid held high
    sel = 0;
    @(negedge clk);
    tx_data = 32'h01; tx_valid = 1'b1;
    acc = 0; ph = 0; gap = 0; nd = 0; rx0 = '0; rx1 = '0;
    pend = m_ready;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (pend) begin
        acc++; pend = 1'b0;
        if (acc == 1) tx_data = 32'h80;
        else tx_valid = 1'b0;
      end
      if (m_done) begin
        if (nd == 0) rx0 = m_rx; else rx1 = m_rx;
        nd++;
      end
      case (ph)
        0: if (!m_cs_n) ph = 1;
        1: if (m_cs_n) begin ph = 2; gap = 1; end
        2: if (m_cs_n) gap++; else ph = 3;
        3: if (m_cs_n) ph = 4;
        default: ;
      endcase
      if (ph == 4) break;
      if (m_ready && tx_valid) pend = 1'b1;
    end
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t3_accepts", acc, 2);
    chk("t3_done", nd, 2);
    chk("t3_gap", gap, 2);
    chk("t3_rx0", rx0, 32'h01);
    chk("t3_rx1", rx1, 32'h80);

    // reset during SHIFT after edges 0..4
    tx_data = 32'h5A; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    nt = 0; w = 0; pv = m_sclk;
    while (nt < 5 && w < 100) begin
      @(negedge clk);
      if (m_sclk != pv) nt++;
      pv = m_sclk; w++;
    end
    chk("t4_edges", nt, 5);
    rst = 1'b1;
    @(negedge clk);
    chk("t4_cs_n",  32'(m_cs_n),  32'd1);
    chk("t4_sclk",  32'(m_sclk),  32'd0);
    chk("t4_mosi",  32'(m_mosi),  32'd0);
    chk("t4_ready", 32'(m_ready), 32'd1);
    chk("t4_rx",    m_rx,         32'd0);
    rst = 1'b0;
    nd = 0;
    for (int t = 0; t < 40; t++) begin
      if (m_done) nd++;
      @(negedge clk);
    end
    chk("t4_nodone", nd, 0);
    frame(32'hC3, 1'b0, bits, nb, cs_lo, nd, rx);
    chk("t4_bits", bits, 32'hC3);
    chk("t4_cs_lo", cs_lo, 34);
    chk("t4_done", nd, 1);
    chk("t4_rx", rx, 32'hC3);

    // 12-bit word, sclk toggling every cycle
    sel = 2;
    @(negedge clk);
    frame(32'hABC, 1'b0, bits, nb, cs_lo, nd, rx);
    chk("t5_bits", bits, 32'hABC);
    chk("t5_nb", nb, 12);
    chk("t5_cs_lo", cs_lo, 25);
    chk("t5_done", nd, 1);
    chk("t5_rx", rx, 32'hABC);

    // tx_data churn and tx_valid pulses while busy, including during STOP
    sel = 0;
    @(negedge clk);
    frame(32'h96, 1'b1, bits, nb, cs_lo, nd, rx);
    chk("t6_bits", bits, 32'h96);
    chk("t6_nb", nb, 8);
    chk("t6_cs_lo", cs_lo, 34);
    chk("t6_done", nd, 1);
    chk("t6_rx", rx, 32'h96);
    chk("t6_idle_cs_n", 32'(m_cs_n), 32'd1);
    chk("t6_idle_ready", 32'(m_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/spi_master_xfer.md
Name: spi_master_xfer

Overview:
Parametrised full-duplex SPI master frame engine and successor to the fixed 6-bit Moore-FSM serial data-out block. It accepts a parallel word over a valid/ready handshake, then drives cs_n, sclk and mosi for one frame. SPI mode (CPOL/CPHA), bit order, word width and sclk rate are configurable. It also samples miso and returns the received word with a one-cycle done pulse. It sits between a host-side register or FIFO and off-chip SPI slaves.

Parameters:
DATA_W, 8, frame length in bits; must be at least 2.
CLK_DIV, 2, clk cycles per sclk half-period; must be at least 1.
CPOL, 0, sclk idle level.
CPHA, 0, 0 means sample on the leading edge; 1 means sample on the trailing edge.
MSB_FIRST, 1, 1 means the MSB is shifted first; 0 means the LSB is shifted first.

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous active-high reset
tx_valid  in  1  host offers tx_data
tx_ready  out  1  engine can accept a frame
tx_data  in  DATA_W  word to transmit
rx_data  out  DATA_W  word received on miso; valid when done=1, held until the next done
done  out  1  one-cycle pulse at frame end
sclk  out  1  serial clock
cs_n  out  1  active-low chip select
mosi  out  1  serial data out
miso  in  1  serial data in

Behaviour:
- Reset values (registered outputs, applied synchronously at the clk edge with rst=1): tx_ready=1, done=0, sclk=CPOL, cs_n=1, mosi=0, rx_data=0. State=IDLE; divider and edge counters=0.
- States:
  - IDLE: tx_ready=1. A cycle with tx_valid=1 and tx_ready=1 at edge T is an accept. On accept, tx_data is latched into the shift register and the next state is SETUP.
  - SETUP: entered at T+1 with cs_n=0 and tx_ready=0. Lasts CLK_DIV cycles (CS lead time). For CPHA=0, mosi presents the first bit from T+1.
  - SHIFT: 2*DATA_W sclk toggles, one every CLK_DIV cycles. The first toggle is at T+1+CLK_DIV.
    - Edge index i runs from 0 to 2*DATA_W-1; even i is a leading edge, odd i is a trailing edge.
    - CPHA=0: miso is sampled on leading edges. mosi advances to the next bit on every trailing edge except the last.
    - CPHA=1: mosi takes the next bit on every leading edge; the first bit appears on edge 0. miso is sampled on trailing edges.
  - HOLD: entered after the last toggle, with sclk back at CPOL. Lasts CLK_DIV cycles; cs_n stays 0.
  - STOP: exactly one cycle. cs_n=1, done=1, rx_data is updated, mosi=0, tx_ready=0. The next state is IDLE.
- Frame timing:
  - cs_n low duration is exactly (2*DATA_W+1)*CLK_DIV cycles.
  - cs_n rises at T+1+(2*DATA_W+1)*CLK_DIV.
  - The earliest next accept is one cycle after cs_n rises, giving a minimum cs_n-high gap of 2 cycles.
- Bit order: MSB_FIRST=1 sends tx_data[DATA_W-1] first. Received bits fill rx_data in the same order, so a loopback (mosi tied to miso) returns rx_data==tx_data.
- Divider: a counter from 0 to CLK_DIV-1, width max(1,$clog2(CLK_DIV)). It wraps and produces a tick on terminal count. It is cleared on every accept and on every state change.
- Edge counter: width $clog2(2*DATA_W)+1. It saturates, never wraps. SHIFT exits when the count reaches 2*DATA_W.
- Boundary conditions:
  - tx_valid while tx_ready=0: ignored; not queued.
  - tx_data changes mid-frame: no effect.
  - miso is sampled only on sample edges; it is don't-care otherwise.
  - rst asserted mid-frame: reset values at the next edge, with no done pulse and no rx_data update.
  - CLK_DIV=1: sclk toggles every cycle, which is legal.
  - tx_valid=1 in the same cycle STOP occurs: not accepted, because tx_ready=0.
- sclk, cs_n and mosi are driven directly from flops, with no combinational path to the pins.

Decomposition:
- Shared package spi_pkg holds:
  - typedef enum logic [2:0] spi_state_e {IDLE, SETUP, SHIFT, HOLD, STOP};
  - a localparam function computing the divider width.
- One sub-module, spi_clk_div (parameter CLK_DIV; ports clk, rst, clr, tick), generates half-period ticks.
- Shift, sample and FSM logic stay in spi_master_xfer.

Test Plan:
1. Defaults (DATA_W=8, CLK_DIV=2, mode 0, MSB first), tx_data=8'hA5, miso looped from mosi -> mosi at the 8 rising sclk edges = 1,0,1,0,0,1,0,1; cs_n low for 34 cycles; done one cycle; rx_data=8'hA5.
2. CPOL=1, CPHA=1, MSB_FIRST=0, tx_data=8'h3C, miso tied to 1 -> sclk idles high; mosi changes on falling (leading) edges as LSB-first 0,0,1,1,1,1,0,0; rx_data=8'hFF.
3. Back-to-back: tx_valid held high with 8'h01 then 8'h80 -> two frames; cs_n high for exactly 2 cycles between them; two done pulses with matching rx_data.
4. rst asserted at SHIFT edge 5 -> next cycle cs_n=1, sclk=CPOL, mosi=0, tx_ready=1; no done pulse; the following frame with 8'hC3 is correct.
5. DATA_W=12, CLK_DIV=1, tx_data=12'hABC -> sclk toggles every cycle; cs_n low 25 cycles; loopback rx_data=12'hABC.
6. tx_data toggled every cycle mid-frame and tx_valid pulsed while busy -> the transmitted word is the accept-cycle value only; no extra frame.
